// File: rtl/dse_record_decoder.sv
// rtl/dse_record_decoder.sv - DSE tagged record stream decoder with phase FSM and output FIFO

// Output buffer: pointer-based FIFO, no bypass, head reads zero while empty
module dse_record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign valid     = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = valid ? mem[rd_ptr[AW-1:0]] : '0;

  // Pointer update; the caller only pushes when there is room (or a pop frees it)
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)          wr_ptr <= wr_ptr + 1'b1;
      if (pop && valid)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module dse_record_decoder #(
  parameter int DEG_DATA_WIDTH  = 512,
  parameter int PERF_DATA_WIDTH = 256,
  parameter int MAGIC_NUM_WIDTH = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      in_enable,
  input  logic [DEG_DATA_WIDTH+MAGIC_NUM_WIDTH-1:0] in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [2:0]                                out_kind,
  output logic [DEG_DATA_WIDTH-1:0]                 out_payload,
  output logic [2:0]                                phase_state,
  output logic [31:0]                               deg_count,
  output logic                                      perf_valid,
  output logic [PERF_DATA_WIDTH-1:0]                perf_data,
  output logic [15:0]                               drop_count,
  output logic [3:0]                                err_flags,
  input  logic                                      err_clear
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RECORD = 3'd2,
    ST_DONE   = 3'd3,
    ST_DRAIN  = 3'd4
  } phase_t;

  localparam logic [MAGIC_NUM_WIDTH-1:0] TAG_EMU     = MAGIC_NUM_WIDTH'(1);
  localparam logic [MAGIC_NUM_WIDTH-1:0] TAG_DEG     = MAGIC_NUM_WIDTH'(2);
  localparam logic [MAGIC_NUM_WIDTH-1:0] TAG_DEGDONE = MAGIC_NUM_WIDTH'(3);
  localparam logic [MAGIC_NUM_WIDTH-1:0] TAG_FINISH  = MAGIC_NUM_WIDTH'(4);

  phase_t state, state_next;
  logic   accept, bad_magic, seq_err, restart, deg_clear, deg_inc, perf_load;
  logic   fifo_full, pop, overflow, do_push;

  logic [MAGIC_NUM_WIDTH-1:0] magic;
  logic [DEG_DATA_WIDTH-1:0]  payload;

  assign magic       = in_data[DEG_DATA_WIDTH+MAGIC_NUM_WIDTH-1:DEG_DATA_WIDTH];
  assign payload     = in_data[DEG_DATA_WIDTH-1:0];
  assign phase_state = state;

  // Phase state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Beat classification and next phase; illegal beats leave the phase untouched
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bad_magic  = 1'b0;
    seq_err    = 1'b0;
    restart    = 1'b0;
    deg_clear  = 1'b0;
    deg_inc    = 1'b0;
    perf_load  = 1'b0;
    if (in_enable) begin
      case (magic)
        TAG_EMU: begin
          state_next = ST_ARMED;
          accept     = 1'b1;
          deg_clear  = 1'b1;
          restart    = (state != ST_IDLE);
        end
        TAG_DEG: begin
          case (state)
            ST_ARMED, ST_RECORD: begin state_next = ST_RECORD; accept = 1'b1; deg_inc = 1'b1; end
            ST_DRAIN:            begin accept = 1'b1; deg_inc = 1'b1; end
            default:             seq_err = 1'b1;
          endcase
        end
        TAG_DEGDONE: begin
          case (state)
            ST_ARMED, ST_RECORD: begin state_next = ST_DONE; accept = 1'b1; end
            ST_DRAIN:            begin state_next = ST_IDLE; accept = 1'b1; end
            default:             seq_err = 1'b1;
          endcase
        end
        TAG_FINISH: begin
          // Finish may arrive before DEGDONE, hence the DRAIN detour
          case (state)
            ST_ARMED, ST_RECORD: begin state_next = ST_DRAIN; accept = 1'b1; perf_load = 1'b1; end
            ST_DONE:             begin state_next = ST_IDLE;  accept = 1'b1; perf_load = 1'b1; end
            default:             seq_err = 1'b1;
          endcase
        end
        default: bad_magic = 1'b1;
      endcase
    end
  end

  assign pop      = out_valid && out_ready;
  assign do_push  = accept && (!fifo_full || pop);
  assign overflow = accept && fifo_full && !pop;

  // DEG counter and finish-vector latch
  always_ff @(posedge clock) begin
    if (reset) begin
      deg_count  <= '0;
      perf_valid <= 1'b0;
      perf_data  <= '0;
    end else begin
      if (deg_clear)                         deg_count <= '0;
      else if (deg_inc && deg_count != '1)   deg_count <= deg_count + 1'b1;
      if (deg_clear) begin
        perf_valid <= 1'b0;
      end else if (perf_load) begin
        perf_valid <= 1'b1;
        perf_data  <= payload[PERF_DATA_WIDTH-1:0];
      end
    end
  end

  // Sticky error flags and drop counter; a new error outranks a same-cycle clear
  always_ff @(posedge clock) begin
    if (reset) begin
      err_flags  <= '0;
      drop_count <= '0;
    end else begin
      err_flags <= (err_clear ? 4'b0000 : err_flags) | {restart, overflow, seq_err, bad_magic};
      if (err_clear)                               drop_count <= 16'(overflow);
      else if (overflow && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end

  dse_record_fifo #(
    .WIDTH (DEG_DATA_WIDTH + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .push_data ({magic[2:0], payload}),
    .pop       (pop),
    .full      (fifo_full),
    .valid     (out_valid),
    .head_data ({out_kind, out_payload})
  );
endmodule
